// File: rtl/mops_sdo_responder.sv
// mops_sdo_responder: CANopen expedited SDO server acting as a MOPS-style
// node model on one CAN bus behind the MOPSHUB. It accepts one 76-bit
// request frame at a time, filters it on node ID, serves a small object
// dictionary (device type, scratch register, ADC channels) and returns
// either a response frame or an SDO abort frame.
module mops_sdo_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] DEVICE_TYPE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  node_id,
  input  logic [75:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [75:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        adc_req,
  output logic [4:0]  adc_ch,
  input  logic [11:0] adc_data,
  input  logic        adc_ack,
  output logic        busy,
  output logic [7:0]  abort_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DECODE   = 2'd1;
  localparam logic [1:0] S_ADC_WAIT = 2'd2;
  localparam logic [1:0] S_SEND     = 2'd3;

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [31:0] ABORT_READ_ONLY = 32'h0601_0002;
  localparam logic [31:0] ABORT_NO_OBJECT = 32'h0602_0000;
  localparam logic [31:0] ABORT_BAD_CMD   = 32'h0504_0001;
  localparam logic [31:0] ABORT_TIMEOUT   = 32'h0504_0000;

  // Build a response frame: COB-ID 0x580+node, RTR=0, data little-endian.
  function automatic logic [75:0] build_frame(
    input logic [6:0]  node,
    input logic [7:0]  cmd,
    input logic [15:0] idx,
    input logic [7:0]  sub,
    input logic [31:0] data
  );
    logic [10:0] cob;
    cob = 11'h580 + {4'b0000, node};
    return {cob, 1'b0, cmd, idx[7:0], idx[15:8], sub,
            data[7:0], data[15:8], data[23:16], data[31:24]};
  endfunction

  // Expedited download command specifiers (1..4 data bytes).
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return (cmd == 8'h23) || (cmd == 8'h27) || (cmd == 8'h2B) || (cmd == 8'h2F);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [75:0]      req_q, req_d;
  logic [6:0]       node_q, node_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [75:0]      rsp_data_q, rsp_data_d;
  logic             rsp_valid_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             adc_req_q, adc_req_d;
  logic [4:0]       adc_ch_q, adc_ch_d;
  logic [7:0]       abort_cnt_q, abort_cnt_d;

  // Fields of the latched request frame.
  logic [10:0] cob_s;
  logic        rtr_s;
  logic [7:0]  cmd_s;
  logic [15:0] idx_s;
  logic [7:0]  sub_s;
  logic [7:0]  sub_m1_s;
  logic [31:0] value_s;
  logic        cob_match_s;
  logic        obj_dev_s;
  logic        obj_scr_s;
  logic        obj_adc_s;
  logic        obj_known_s;

  assign cob_s       = req_q[75:65];
  assign rtr_s       = req_q[64];
  assign cmd_s       = req_q[63:56];
  assign idx_s       = {req_q[47:40], req_q[55:48]};
  assign sub_s       = req_q[39:32];
  assign sub_m1_s    = sub_s - 8'd1;
  assign value_s     = {req_q[7:0], req_q[15:8], req_q[23:16], req_q[31:24]};
  assign cob_match_s = (cob_s == (11'h600 + {4'b0000, node_q}));
  assign obj_dev_s   = (idx_s == 16'h1000) && (sub_s == 8'd0);
  assign obj_scr_s   = (idx_s == 16'h2200) && (sub_s == 8'd0);
  assign obj_adc_s   = (idx_s == 16'h2400) && (sub_s >= 8'd1) && (sub_s <= 8'd32);
  assign obj_known_s = obj_dev_s || obj_scr_s || obj_adc_s;

  // Next-state and datapath decisions for the request/response sequence.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    node_d      = node_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    adc_req_d   = adc_req_q;
    adc_ch_d    = adc_ch_q;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d   = req_data;
          node_d  = node_id;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (!cob_match_s || rtr_s) begin
          // Not addressed to us (or a remote frame): silently drop.
          state_d = S_IDLE;
        end else if (cmd_s == 8'h40) begin
          if (obj_dev_s) begin
            rsp_data_d = build_frame(node_q, 8'h43, idx_s, sub_s, DEVICE_TYPE);
            state_d    = S_SEND;
          end else if (obj_scr_s) begin
            rsp_data_d = build_frame(node_q, 8'h43, idx_s, sub_s, scratch_q);
            state_d    = S_SEND;
          end else if (obj_adc_s) begin
            adc_ch_d  = sub_m1_s[4:0];
            adc_req_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ADC_WAIT;
          end else begin
            rsp_data_d = build_frame(node_q, 8'h80, idx_s, sub_s, ABORT_NO_OBJECT);
            state_d    = S_SEND;
          end
        end else if (is_write_cmd(cmd_s)) begin
          if ((cmd_s == 8'h23) && obj_scr_s) begin
            scratch_d  = value_s;
            rsp_data_d = build_frame(node_q, 8'h60, idx_s, sub_s, 32'h0000_0000);
          end else if (obj_known_s) begin
            rsp_data_d = build_frame(node_q, 8'h80, idx_s, sub_s, ABORT_READ_ONLY);
          end else begin
            rsp_data_d = build_frame(node_q, 8'h80, idx_s, sub_s, ABORT_NO_OBJECT);
          end
          state_d = S_SEND;
        end else begin
          rsp_data_d = build_frame(node_q, 8'h80, idx_s, sub_s, ABORT_BAD_CMD);
          state_d    = S_SEND;
        end
      end
      S_ADC_WAIT: begin
        // An ack in the timeout cycle still yields a normal response.
        if (adc_ack) begin
          adc_req_d  = 1'b0;
          rsp_data_d = build_frame(node_q, 8'h43, idx_s, sub_s, {20'h00000, adc_data});
          state_d    = S_SEND;
        end else if (cnt_q == CNT_LAST) begin
          adc_req_d  = 1'b0;
          rsp_data_d = build_frame(node_q, 8'h80, idx_s, sub_s, ABORT_TIMEOUT);
          state_d    = S_SEND;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_SEND: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
          if ((rsp_data_q[63:56] == 8'h80) && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
          end else begin
            abort_cnt_d = abort_cnt_q;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= 76'd0;
      node_q      <= 7'd0;
      scratch_q   <= 32'd0;
      cnt_q       <= '0;
      rsp_data_q  <= 76'd0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      adc_req_q   <= 1'b0;
      adc_ch_q    <= 5'd0;
      abort_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      node_q      <= node_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= (state_d == S_SEND);
      req_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      adc_req_q   <= adc_req_d;
      adc_ch_q    <= adc_ch_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign adc_req   = adc_req_q;
  assign adc_ch    = adc_ch_q;
  assign busy      = busy_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: doc/mops_sdo_responder.md
Name: mops_sdo_responder

Overview:
Synthesisable CANopen SDO server. It emulates the responding end of the MOPSHUB downlink: the hub sends expedited SDO requests to a MOPS-style node, and this block returns the matching response frame for the uplink path. It accepts 76-bit request frames, filters them on node ID, serves a small object dictionary, and fetches ADC channels through a request/acknowledge port. It also builds SDO abort frames. It is used as an RTL node model on the CAN-bus side of the hub, with one instance per bus.

Parameters:
TIMEOUT_CYCLES, 1000, clk cycles to wait for adc_ack before aborting
DEVICE_TYPE, 32'h0000_0000, value returned for object 0x1000 sub 0

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous active-low reset
node_id  in  7  node ID; sampled when a request is accepted
req_data  in  76  request frame: [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7 (byte0 = [63:56])
req_valid  in  1  request frame valid
req_ready  out  1  block can accept a request
rsp_data  out  76  response frame, same layout as req_data
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  consumer accepts response
adc_req  out  1  ADC conversion request (level)
adc_ch  out  5  ADC channel requested
adc_data  in  12  ADC result
adc_ack  in  1  single-cycle strobe; adc_data valid in that cycle
busy  out  1  high in any state except IDLE
abort_cnt  out  8  number of abort responses sent; saturates at 255

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - req_ready=1 after release; rsp_valid=0, rsp_data=0.
  - adc_req=0, adc_ch=0, busy=0, abort_cnt=0.
  - Scratch register (0x2200) =0, timeout counter =0.
  - Reset mid-operation discards the frame in flight; no partial response is emitted.
- States: IDLE, DECODE, ADC_WAIT, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_data and node_id, go to DECODE. req_ready drops in the next cycle.
- DECODE (one cycle). Fields: cmd=byte0, idx={byte2,byte1}, sub=byte3, value={byte7,byte6,byte5,byte4}.
  - Drop case: COB-ID != 0x600+node_id, or RTR=1. Return to IDLE with no response, no abort, no counter change.
  - cmd=0x40 (upload), idx=0x1000, sub=0: response cmd 0x43, data=DEVICE_TYPE. Go to SEND.
  - cmd=0x40, idx=0x2200, sub=0: response 0x43, data=scratch. Go to SEND.
  - cmd=0x40, idx=0x2400, sub 1..32: adc_ch=sub-1, adc_req=1, timeout counter cleared. Go to ADC_WAIT.
  - cmd=0x23, idx=0x2200, sub=0: scratch<=value; response cmd 0x60, data=0. Go to SEND.
  - Write commands 0x23, 0x27, 0x2B, 0x2F to any other object: abort 0x06010002 (read-only object).
  - Known cmd (0x40 or a write) with unknown idx/sub: abort 0x06020000.
  - Any other cmd: abort 0x05040001.
- ADC_WAIT:
  - On adc_ack: adc_req=0; response 0x43, data={20'h0,adc_data}. Go to SEND.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: adc_req=0, abort 0x05040000. Go to SEND.
  - An adc_ack in the same cycle as the timeout wins: a normal response is sent.
  - adc_ack outside ADC_WAIT is ignored.
- Response frame:
  - COB-ID = 0x580+node_id (latched value), RTR=0.
  - byte0=cmd, byte1/2 = idx low/high, byte3 = sub, bytes4..7 = data, little-endian (byte4 = LSB).
  - Abort frames use cmd 0x80 and carry the abort code in bytes4..7, little-endian.
- SEND:
  - rsp_valid=1; rsp_data stays stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0 in the next cycle, return to IDLE, req_ready=1.
  - abort_cnt increments on acceptance of an abort frame.
- Latency, where T is the accept cycle:
  - Non-ADC requests: rsp_valid is high from T+2.
  - ADC requests: adc_req is high from T+2; rsp_valid is high in the cycle after adc_ack.
  - A request can be accepted in the cycle after response acceptance at the earliest.
  - Only one request is outstanding at a time; requests are never queued.

Test Plan:
1. node_id=0x05; request COB 0x605 with bytes 40 00 24 03 00 00 00 00. Ack after 10 cycles with adc_data=0xABC → adc_ch=2; response COB 0x585, bytes 43 00 24 03 BC 0A 00 00.
2. Write 23 00 22 00 78 56 34 12, then read 40 00 22 00 → first response 60 00 22 00 00 00 00 00; second response 43 00 22 00 78 56 34 12.
3. Request with COB 0x606 (node_id=0x05), and a separate request with RTR=1 → no rsp_valid for 50 cycles; req_ready=1 again 2 cycles after accept; abort_cnt=0.
4. ADC read of sub 1 with no adc_ack → after TIMEOUT_CYCLES, response 80 00 24 01 00 00 04 05; adc_req=0; abort_cnt=1. Read of idx 0x3000 → abort 00 00 02 06. cmd 0x55 → abort 01 00 04 05.
5. Hold rsp_ready=0 for 20 cycles during a response → rsp_data stable and req_ready=0 throughout; accepted on release.
6. Assert rst=0 while in ADC_WAIT → adc_req, busy and rsp_valid go to 0 immediately (asynchronous); scratch=0; no response after release.
